calltrace_dump: RTL and testbench

- Sequencer and bus arbiter in front of the calltrace monitor.
- On a hardware trigger (error trap, watchdog), it freezes the current process's calltrace stack and reads every stacked LNK value into a local snapshot buffer, then unfreezes the stack.
- It shares the calltrace bus slave between the CPU (pass-through) and its own sequencer.
- Software later reads the snapshot without touching the live stacks.

---
 rtl/calltrace_dump.sv | 228 ++++++++++++++++++++++
 tb/tb_calltrace_dump.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/calltrace_dump.sv
// Calltrace dump sequencer: on trigger, freezes the current process's calltrace stack,
// copies every stacked LNK into a snapshot buffer, unfreezes it, and arbitrates the bus.
module calltrace_dump #(
  parameter int unsigned DUMP_DEPTH = 32,
  parameter int unsigned IDX_W      = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_stb,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_addr,
  input  logic [23:0] cpu_din,
  output logic [31:0] cpu_dout,
  output logic        cpu_ack,
  input  logic        trig,
  input  logic [4:0]  cp_pid,
  output logic        ct_stb,
  output logic        ct_we,
  output logic        ct_addr,
  output logic [23:0] ct_din,
  input  logic [31:0] ct_dout,
  input  logic        ct_ack
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StFreeze   = 3'd1;
  localparam logic [2:0] StStat     = 3'd2;
  localparam logic [2:0] StRead     = 3'd3;
  localparam logic [2:0] StUnfreeze = 3'd4;

  logic [2:0]     state_q, state_d;
  logic           armed_q, armed_d;
  logic           valid_q, valid_d;
  logic           busy_q, busy_d;
  logic           aborted_q, aborted_d;
  logic           trunc_q, trunc_d;
  logic           missed_q, missed_d;
  logic [7:0]     n_q, n_d;
  logic [4:0]     pid_q, pid_d;
  logic [IDX_W:0] rd_idx_q, rd_idx_d;
  logic [IDX_W:0] wr_idx_q, wr_idx_d;

  logic [23:0] dump_mem_q [DUMP_DEPTH];
  logic        mem_we;

  logic        in_seq;
  logic        abort;
  logic        rd_hit;
  logic        dump_rd;
  logic        ctrl_wr;
  logic [7:0]  ct_count;
  logic [31:0] status_word;

  assign in_seq   = (state_q == StFreeze) || (state_q == StStat) || (state_q == StRead);
  // A process switch mid-dump means the frozen stack is no longer the one on the bus.
  assign abort    = in_seq && (cp_pid != pid_q);
  assign rd_hit   = 32'(rd_idx_q) < 32'(n_q);
  assign dump_rd  = cpu_stb && !cpu_we && (cpu_addr == 2'd2);
  assign ctrl_wr  = cpu_stb && cpu_we && (cpu_addr == 2'd3);
  assign ct_count = ct_dout[15:8];
  assign status_word = {valid_q, busy_q, aborted_q, trunc_q, missed_q, 6'b0, pid_q, 8'b0, n_q};

  // Calltrace bus: CPU pass-through in idle, sequencer-owned otherwise.
  always_comb begin
    ct_stb  = 1'b0;
    ct_we   = 1'b0;
    ct_addr = 1'b0;
    ct_din  = 24'h0;
    case (state_q)
      StIdle: begin
        ct_stb  = cpu_stb && !cpu_addr[1];
        ct_we   = cpu_we;
        ct_addr = cpu_addr[0];
        ct_din  = cpu_din;
      end
      StFreeze: begin
        ct_stb  = !abort;
        ct_we   = 1'b1;
        ct_addr = 1'b1;
        ct_din  = {11'b0, pid_q, 8'h04};
      end
      StStat: begin
        ct_stb  = !abort;
        ct_addr = 1'b1;
      end
      StRead: begin
        ct_stb  = !abort;
      end
      StUnfreeze: begin
        ct_stb  = 1'b1;
        ct_we   = 1'b1;
        ct_addr = 1'b1;
        ct_din  = {11'b0, pid_q, 8'h08};
      end
      default: ;
    endcase
  end

  always_comb begin
    cpu_ack  = 1'b0;
    cpu_dout = 32'h0;
    if (cpu_addr[1]) begin
      cpu_ack = cpu_stb;
      if (cpu_stb && !cpu_we) begin
        if (!cpu_addr[0]) begin
          cpu_dout = rd_hit ? {8'b0, dump_mem_q[rd_idx_q[IDX_W-1:0]]} : 32'h0;
        end else begin
          cpu_dout = status_word;
        end
      end
    end else if (state_q == StIdle) begin
      cpu_ack  = ct_ack;
      cpu_dout = ct_ack ? ct_dout : 32'h0;
    end
  end

  always_comb begin
    state_d   = state_q;
    armed_d   = armed_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    aborted_d = aborted_q;
    trunc_d   = trunc_q;
    missed_d  = missed_q;
    n_d       = n_q;
    pid_d     = pid_q;
    rd_idx_d  = rd_idx_q;
    wr_idx_d  = wr_idx_q;
    mem_we    = 1'b0;

    if (dump_rd && rd_hit) begin
      rd_idx_d = rd_idx_q + 1'b1;
    end
    if (ctrl_wr) begin
      if (cpu_din[0]) armed_d = 1'b1;
      if (cpu_din[1]) armed_d = 1'b0;
      if (cpu_din[2] && !busy_q) begin
        valid_d   = 1'b0;
        aborted_d = 1'b0;
        trunc_d   = 1'b0;
        missed_d  = 1'b0;
        rd_idx_d  = '0;
      end
    end
    if (trig && armed_q && (valid_q || busy_q)) begin
      missed_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (trig && armed_q && !valid_q && !busy_q) begin
          pid_d     = cp_pid;
          aborted_d = 1'b0;
          trunc_d   = 1'b0;
          busy_d    = 1'b1;
          state_d   = StFreeze;
        end
      end
      StFreeze: begin
        state_d = StStat;
      end
      StStat: begin
        trunc_d  = 32'(ct_count) > DUMP_DEPTH;
        n_d      = (32'(ct_count) > DUMP_DEPTH) ? 8'(DUMP_DEPTH) : ct_count;
        wr_idx_d = '0;
        state_d  = (ct_count == 8'd0) ? StUnfreeze : StRead;
      end
      StRead: begin
        mem_we   = 1'b1;
        wr_idx_d = wr_idx_q + 1'b1;
        if (32'(wr_idx_q) + 32'd1 == 32'(n_q)) state_d = StUnfreeze;
      end
      StUnfreeze: begin
        valid_d  = 1'b1;
        busy_d   = 1'b0;
        rd_idx_d = '0;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // No unfreeze on abort: it would land on the wrong process's stack.
    if (abort) begin
      mem_we    = 1'b0;
      aborted_d = 1'b1;
      busy_d    = 1'b0;
      trunc_d   = trunc_q;
      n_d       = n_q;
      wr_idx_d  = wr_idx_q;
      state_d   = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      armed_q   <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      aborted_q <= 1'b0;
      trunc_q   <= 1'b0;
      missed_q  <= 1'b0;
      n_q       <= 8'd0;
      pid_q     <= 5'd0;
      rd_idx_q  <= '0;
      wr_idx_q  <= '0;
    end else begin
      state_q   <= state_d;
      armed_q   <= armed_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      aborted_q <= aborted_d;
      trunc_q   <= trunc_d;
      missed_q  <= missed_d;
      n_q       <= n_d;
      pid_q     <= pid_d;
      rd_idx_q  <= rd_idx_d;
      wr_idx_q  <= wr_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      dump_mem_q[wr_idx_q[IDX_W-1:0]] <= ct_dout[23:0];
    end
  end

endmodule

// File: tb/tb_calltrace_dump.sv
// Randomized self-checking bench for calltrace_dump with a behavioural calltrace stack model.
module tb_calltrace_dump;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_stb, cpu_we;
  logic [1:0]  cpu_addr;
  logic [23:0] cpu_din;
  logic [31:0] cpu_dout;
  logic        cpu_ack;
  logic        trig;
  logic [4:0]  cp_pid;
  logic        ct_stb, ct_we, ct_addr;
  logic [23:0] ct_din;
  logic [31:0] ct_dout;
  logic        ct_ack;

  int checks = 0;
  int failures = 0;

  // Calltrace stack model: stack_mem[st_cnt-1] is the top entry.
  logic [23:0] stack_mem [64];
  int st_cnt = 0;
  int rdptr = 0;
  int n_freeze = 0;
  int n_unfreeze = 0;

  calltrace_dump #(.DUMP_DEPTH(32), .IDX_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_stb(cpu_stb), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .trig(trig), .cp_pid(cp_pid),
    .ct_stb(ct_stb), .ct_we(ct_we), .ct_addr(ct_addr), .ct_din(ct_din),
    .ct_dout(ct_dout), .ct_ack(ct_ack)
  );

  always #5 clk = ~clk;

  assign ct_ack = ct_stb;

  always_comb begin
    ct_dout = 32'h0;
    if (ct_addr) ct_dout = {16'h0, 8'(st_cnt), 8'h00};
    else if (rdptr < st_cnt) ct_dout = {8'hA5, stack_mem[6'(st_cnt - 1 - rdptr)]};
  end

  always @(posedge clk) begin
    if (ct_stb && ct_ack) begin
      if (ct_we && ct_addr && ct_din[7:0] == 8'h04) begin
        rdptr    <= 0;
        n_freeze <= n_freeze + 1;
      end else if (ct_we && ct_addr && ct_din[7:0] == 8'h08) begin
        n_unfreeze <= n_unfreeze + 1;
      end else if (!ct_we && !ct_addr) begin
        rdptr <= rdptr + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] st(input bit v, input bit b, input bit a, input bit t,
                                     input bit m, input logic [4:0] p, input logic [7:0] n);
    return {v, b, a, t, m, 6'b0, p, 8'b0, n};
  endfunction

  task automatic cpu_rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    cpu_stb = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    #1;
    d = cpu_dout;
    @(posedge clk);
    #1 cpu_stb = 1'b0;
  endtask

  task automatic cpu_wr(input logic [1:0] a, input logic [23:0] v);
    @(negedge clk);
    cpu_stb = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_din = v;
    @(posedge clk);
    #1 cpu_stb = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic fill_stack(input int c);
    st_cnt = c;
    for (int k = 0; k < 64; k++) stack_mem[k] = 24'($urandom);
  endtask

  // Expected bus traffic: freeze write, status read, n data reads, unfreeze write.
  task automatic run_dump(input int c, input logic [4:0] p, input bit stall);
    int n;
    logic [31:0] e;
    n = (c > 32) ? 32 : c;
    @(negedge clk);
    trig = 1'b1;
    for (int i = 0; i < n + 3; i++) begin
      @(negedge clk);
      trig = 1'b0;
      if (stall && i >= 2) begin
        cpu_stb = 1'b1; cpu_we = 1'b0; cpu_addr = 2'd1;
      end else if (!stall) begin
        cpu_stb = 1'b1; cpu_we = 1'b0; cpu_addr = 2'd3;
      end
      #1;
      if (i == 0) e = {5'b0, 3'b111, 11'b0, p, 8'h04};
      else if (i == 1) e = {5'b0, 3'b101, 24'h0};
      else if (i < n + 2) e = {5'b0, 3'b100, 24'h0};
      else e = {5'b0, 3'b111, 11'b0, p, 8'h08};
      chk("bus_seq", {5'b0, ct_stb, ct_we, ct_addr, ct_we ? ct_din : 24'h0}, e);
      if (stall && i >= 2) chk("stall_ack", {31'b0, cpu_ack}, 32'h0);
      if (!stall) chk("busy_flags", {30'b0, cpu_dout[31:30]}, 32'h1);
    end
    @(negedge clk);
    cpu_stb = 1'b1; cpu_we = 1'b0; cpu_addr = stall ? 2'd1 : 2'd3;
    #1;
    if (stall) begin
      chk("stall_release_ack", {31'b0, cpu_ack}, 32'h1);
      chk("stall_release_dout", cpu_dout, {16'h0, 8'(c), 8'h00});
    end else begin
      chk("done_status", cpu_dout, st(1, 0, 0, c > 32, 0, p, 8'(n)));
    end
    cpu_stb = 1'b0;
    #1;
    chk("idle_stb", {31'b0, ct_stb}, 32'h0);
  endtask

  task automatic readback(input int c);
    int n;
    logic [31:0] d;
    n = (c > 32) ? 32 : c;
    for (int k = 0; k <= n; k++) begin
      cpu_rd(2'd2, d);
      chk("buf", d, (k < n) ? {8'h0, stack_mem[6'(c - 1 - k)]} : 32'h0);
    end
    cpu_rd(2'd2, d);
    chk("buf_past_end", d, 32'h0);
    cpu_wr(2'd3, 24'h4);
  endtask

  initial begin
    logic [31:0] d;
    int fz, uf, c;
    logic [4:0] p;
    rst_n = 1'b0; cpu_stb = 1'b0; cpu_we = 1'b0; cpu_addr = 2'd0; cpu_din = 24'h0;
    trig = 1'b0; cp_pid = 5'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ack", {31'b0, cpu_ack}, 32'h0);
    chk("rst_stb", {31'b0, ct_stb}, 32'h0);
    cpu_rd(2'd3, d);
    chk("rst_status", d, 32'h0);
    cpu_wr(2'd3, 24'h1);

    // Three-entry stack, C on top.
    cp_pid = 5'd5;
    fill_stack(3);
    stack_mem[0] = 24'h000100; stack_mem[1] = 24'h000200; stack_mem[2] = 24'h000300;
    run_dump(3, 5'd5, 1'b0);
    readback(3);
    chk("freeze_cnt", n_freeze, 1);
    chk("unfreeze_cnt", n_unfreeze, 1);

    fill_stack(0);
    run_dump(0, 5'd5, 1'b0);
    readback(0);

    fill_stack(40);
    run_dump(40, 5'd5, 1'b0);
    readback(40);

    fill_stack(3);
    run_dump(3, 5'd5, 1'b1);
    readback(3);

    // Trigger while a snapshot is still valid.
    cp_pid = 5'd9;
    fill_stack(2);
    run_dump(2, 5'd9, 1'b0);
    fz = n_freeze;
    @(negedge clk); trig = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); trig = 1'b0; #1;
      chk("missed_no_traffic", {31'b0, ct_stb}, 32'h0);
    end
    chk("missed_freeze_cnt", n_freeze, fz);
    cpu_rd(2'd3, d);
    chk("missed_status", d, st(1, 0, 0, 0, 1, 5'd9, 8'd2));
    cpu_wr(2'd3, 24'h4);
    cpu_rd(2'd3, d);
    chk("cleared_status", d, st(0, 0, 0, 0, 0, 5'd9, 8'd2));

    // Unarmed trigger does nothing.
    cpu_wr(2'd3, 24'h2);
    @(negedge clk); trig = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); trig = 1'b0; #1;
      chk("unarmed_no_traffic", {31'b0, ct_stb}, 32'h0);
    end
    cpu_rd(2'd3, d);
    chk("unarmed_status", d, st(0, 0, 0, 0, 0, 5'd9, 8'd2));
    cpu_wr(2'd3, 24'h1);

    // Process switch during the second data read aborts the dump.
    cp_pid = 5'd5;
    fill_stack(3);
    uf = n_unfreeze;
    @(negedge clk); trig = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); trig = 1'b0;
      if (i == 3) cp_pid = 5'd7;
      #1;
      if (i == 3) chk("abort_stb", {31'b0, ct_stb}, 32'h0);
    end
    cpu_rd(2'd3, d);
    chk("abort_status", d, st(0, 0, 1, 0, 0, 5'd5, 8'd3));
    chk("abort_no_unfreeze", n_unfreeze, uf);
    cp_pid = 5'd5;
    cpu_wr(2'd1, 24'h000508);
    chk("sw_unfreeze_passthru", n_unfreeze, uf + 1);

    // Reset in the middle of the data reads.
    fill_stack(5);
    @(negedge clk); trig = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); trig = 1'b0;
      if (i == 3) rst_n = 1'b0;
    end
    @(negedge clk); rst_n = 1'b1; #1;
    chk("midrst_stb", {31'b0, ct_stb}, 32'h0);
    cpu_rd(2'd3, d);
    chk("midrst_status", d, 32'h0);
    cpu_wr(2'd3, 24'h1);
    run_dump(5, 5'd5, 1'b0);
    readback(5);

    for (int it = 0; it < 6; it++) begin
      p = 5'($urandom_range(0, 31));
      c = int'($urandom_range(0, 40));
      cp_pid = p;
      fill_stack(c);
      run_dump(c, p, 1'b0);
      readback(c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
